// File: rtl/pc_pkg.sv
// pc_pkg: shared constants for the program-counter unit.
//   MODE_* : encodings of the 3-bit next-PC operation presented on pc_unit.mode.
//            Encodings 3'b110 and 3'b111 are unassigned and act as HOLD.
package pc_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_SEQ    = 3'b001;
  localparam logic [2:0] MODE_BRANCH = 3'b010;
  localparam logic [2:0] MODE_JUMP   = 3'b011;
  localparam logic [2:0] MODE_CALL   = 3'b100;
  localparam logic [2:0] MODE_RET    = 3'b101;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (clears pointer, count, underflow)
//   push      : store push_data as the new top; when full the oldest entry is overwritten
//   pop       : drop the top entry; when empty, only the sticky underflow is set
//   push_data : return address to store
//   top       : most recently pushed entry still on the stack
//   count     : number of valid entries, 0..RAS_DEPTH
//   underflow : sticky, set by a pop while empty, cleared only by rst
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam logic [PW-1:0] LAST_IDX = PW'(RAS_DEPTH-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;

  // Pointer wraps explicitly so non-power-of-two depths work.
  assign ptr_inc = (ptr_q == LAST_IDX) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? LAST_IDX : ptr_q - PW'(1);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (push) begin
      // Pushing while full overwrites the oldest slot; count saturates.
      ptr_d   = ptr_inc;
      count_d = (count_q == FULL_CNT) ? count_q : count_q + CW'(1);
    end else if (pop) begin
      if (count_q != '0) begin
        ptr_d   = ptr_dec;
        count_d = count_q - CW'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry contents carry no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_inc] <= push_data;
  end

  assign top       = mem_q[ptr_q];
  assign count     = count_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC mux and return-address stack.
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset, PC <- RESET_VECTOR, stack emptied
//   ena           : execute mode at the edge; when low everything holds
//   mode          : next-PC operation (see pc_pkg MODE_*)
//   offset        : two's-complement branch displacement
//   target        : absolute JUMP/CALL destination
//   data_out      : current PC, straight from the PC register
//   ras_count     : stack occupancy
//   ras_full      : ras_count == RAS_DEPTH
//   ras_empty     : ras_count == 0
//   ras_underflow : sticky, RET seen with an empty stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'h0040_0000),
  parameter int                STEP         = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic [2:0]                     mode,
  input  logic [WIDTH-1:0]               offset,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               data_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic             ras_push, ras_pop;

  // All arithmetic is modulo 2^WIDTH; carries out are simply dropped.
  assign pc_seq = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (ena) begin
      case (mode)
        MODE_SEQ:    pc_d = pc_seq;
        MODE_BRANCH: pc_d = pc_seq + offset;
        MODE_JUMP:   pc_d = target;
        MODE_CALL: begin
          pc_d     = target;
          ras_push = 1'b1;
        end
        MODE_RET: begin
          // The pop is still issued when empty so the stack records underflow.
          ras_pop = 1'b1;
          pc_d    = ras_empty ? pc_seq : ras_top;
        end
        default:     pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .underflow (ras_underflow)
  );

  assign data_out  = pc_q;
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  mode;
  logic [31:0] offset;
  logic [31:0] target;
  logic [31:0] data_out;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    logic        uf;
    string       nm;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] HOLD = 3'b000, SEQ = 3'b001, BR = 3'b010, JMP = 3'b011,
                         CALL = 3'b100, RET = 3'b101, M6 = 3'b110, M7 = 3'b111;

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .mode          (mode),
    .offset        (offset),
    .target        (target),
    .data_out      (data_out),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Drive one command and record what the PC/stack must show after the next edge.
  task automatic step(input logic e, input logic [2:0] m, input logic [31:0] off,
                      input logic [31:0] tgt, input logic [31:0] exp_pc,
                      input int cnt, input logic uf, input string nm);
    exp_t x;
    @(negedge clk);
    ena    = e;
    mode   = m;
    offset = off;
    target = tgt;
    x.pc = exp_pc; x.cnt = cnt; x.uf = uf; x.nm = nm;
    sb.push_back(x);
  endtask

  // Reset raised between edges; outputs must change before any clock edge.
  task automatic mid_reset(input string nm);
    @(negedge clk);
    ena  = 1'b0;
    mode = HOLD;
    #2 rst = 1'b1;
    #1;
    check({nm, ".pc"},    64'(data_out), 64'h0040_0000);
    check({nm, ".cnt"},   64'(ras_count), 64'd0);
    check({nm, ".empty"}, 64'(ras_empty), 64'd1);
    check({nm, ".full"},  64'(ras_full), 64'd0);
    check({nm, ".uf"},    64'(ras_underflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: the PC is sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check({x.nm, ".pc"},    64'(data_out), 64'(x.pc));
      check({x.nm, ".cnt"},   64'(ras_count), 64'(x.cnt));
      check({x.nm, ".full"},  64'(ras_full), 64'(x.cnt == 4));
      check({x.nm, ".empty"}, 64'(ras_empty), 64'(x.cnt == 0));
      check({x.nm, ".uf"},    64'(ras_underflow), 64'(x.uf));
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; mode = HOLD; offset = '0; target = '0;
    #1;
    check("reset.pc",    64'(data_out), 64'h0040_0000);
    check("reset.cnt",   64'(ras_count), 64'd0);
    check("reset.empty", 64'(ras_empty), 64'd1);
    check("reset.full",  64'(ras_full), 64'd0);
    check("reset.uf",    64'(ras_underflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1, SEQ,  0, 0, 32'h0040_0004, 0, 0, "seq1");
    step(1, SEQ,  0, 0, 32'h0040_0008, 0, 0, "seq2");
    step(1, SEQ,  0, 0, 32'h0040_000C, 0, 0, "seq3");
    step(1, SEQ,  0, 0, 32'h0040_0010, 0, 0, "seq4");
    step(1, BR,   32'hFFFF_FFF0, 0, 32'h0040_0004, 0, 0, "branch_back");
    step(0, SEQ,  0, 0, 32'h0040_0004, 0, 0, "hold_ena0_seq");
    step(0, CALL, 0, 32'h999, 32'h0040_0004, 0, 0, "hold_ena0_call");
    step(1, BR,   32'h0000_0010, 0, 32'h0040_0018, 0, 0, "branch_fwd");
    step(1, JMP,  0, 32'h0000_0800, 32'h0000_0800, 0, 0, "jump");
    step(1, HOLD, 0, 0, 32'h0000_0800, 0, 0, "hold_mode");

    mid_reset("rst1");
    step(1, CALL, 0, 32'h100, 32'h0000_0100, 1, 0, "call100");
    step(1, CALL, 0, 32'h200, 32'h0000_0200, 2, 0, "call200");
    step(1, RET,  0, 0, 32'h0000_0104, 1, 0, "ret_inner");
    step(1, RET,  0, 0, 32'h0040_0004, 0, 0, "ret_outer");

    step(1, CALL, 0, 32'h1000, 32'h0000_1000, 1, 0, "ovf_call1");
    step(1, CALL, 0, 32'h2000, 32'h0000_2000, 2, 0, "ovf_call2");
    step(1, CALL, 0, 32'h3000, 32'h0000_3000, 3, 0, "ovf_call3");
    step(1, CALL, 0, 32'h4000, 32'h0000_4000, 4, 0, "ovf_call4");
    step(1, CALL, 0, 32'h5000, 32'h0000_5000, 4, 0, "ovf_call5");
    step(1, RET,  0, 0, 32'h0000_4004, 3, 0, "ovf_ret1");
    step(1, RET,  0, 0, 32'h0000_3004, 2, 0, "ovf_ret2");
    step(1, RET,  0, 0, 32'h0000_2004, 1, 0, "ovf_ret3");
    step(1, RET,  0, 0, 32'h0000_1004, 0, 0, "ovf_ret4");
    step(1, RET,  0, 0, 32'h0000_1008, 0, 1, "ovf_ret5_underflow");
    step(1, M6,   0, 0, 32'h0000_1008, 0, 1, "mode6_hold");
    step(1, M7,   0, 0, 32'h0000_1008, 0, 1, "mode7_hold");
    step(0, RET,  0, 0, 32'h0000_1008, 0, 1, "ret_ena0");
    step(1, RET,  0, 0, 32'h0000_100C, 0, 1, "ret_empty_again");

    step(1, JMP,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, "jump_top");
    step(1, SEQ,  0, 0, 32'h0000_0000, 0, 1, "seq_wrap");
    step(1, BR,   32'hFFFF_FFF8, 0, 32'hFFFF_FFFC, 0, 1, "branch_wrap");
    step(1, CALL, 0, 32'h300, 32'h0000_0300, 1, 1, "call_before_rst");

    mid_reset("rst2");
    step(1, RET,  0, 0, 32'h0040_0004, 0, 1, "ret_after_rst");

    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0040_0000, giving the PC value loaded by reset.
REQ-003 The block SHALL have parameter STEP, default 4, giving the sequential increment.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack entry count (legal range 2..16).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port ena, input, 1 bit: when high, the mode is executed at the clock edge; when low, all state holds.
REQ-008 The block SHALL have port mode, input, 3 bits: the next-PC operation (encodings in REQ-013).
REQ-009 The block SHALL have port offset, input, WIDTH bits: the two's-complement branch displacement.
REQ-010 The block SHALL have port target, input, WIDTH bits: the absolute jump or call destination.
REQ-011 The block SHALL have port data_out, output, WIDTH bits: the current PC, driven directly from a register.
REQ-012 The block SHALL have status ports ras_count (output, $clog2(RAS_DEPTH+1) bits), ras_full (output, 1 bit), ras_empty (output, 1 bit) and ras_underflow (output, 1 bit, sticky).

Function
REQ-013 Mode encodings SHALL be: 000 HOLD; 001 SEQ; 010 BRANCH; 011 JUMP; 100 CALL; 101 RET; 110 and 111 behave as HOLD.
REQ-014 With ena=1, the next PC SHALL be: HOLD -> pc; SEQ -> pc+STEP; BRANCH -> pc+STEP+offset; JUMP -> target; CALL -> target; RET -> the top stack entry.
REQ-015 All PC arithmetic SHALL be modulo 2^WIDTH: wrap-around occurs without a flag, e.g. pc=FFFF_FFFC with SEQ gives 0000_0000.
REQ-016 data_out SHALL update one edge after the command is sampled; there SHALL be no combinational path from any input to data_out.
REQ-017 CALL SHALL push pc+STEP onto the stack and increment ras_count in the same edge as the PC update.
REQ-018 CALL with the stack full SHALL still push: the oldest entry is discarded (circular), ras_count stays at RAS_DEPTH, and no error is raised.
REQ-019 RET with ras_count>0 SHALL pop: pc takes the top entry and ras_count decrements.
REQ-020 RET with the stack empty SHALL act as SEQ and set ras_underflow.
REQ-021 ras_underflow SHALL remain set until rst.
REQ-022 ras_full SHALL equal (ras_count==RAS_DEPTH), and ras_empty SHALL equal (ras_count==0); both SHALL be combinational decodes of the count register.
REQ-023 With ena=0, pc, stack contents, ras_count and ras_underflow SHALL all hold, regardless of mode.

Reset
REQ-024 While rst=1, the block SHALL immediately (without waiting for a clk edge) force data_out=RESET_VECTOR, ras_count=0, ras_empty=1, ras_full=0 and ras_underflow=0.
REQ-025 Reset SHALL take priority over ena and mode; stack entry contents are don't-care after reset.
REQ-026 A reset asserted mid-sequence (e.g. between CALL and RET) SHALL abandon all stack state; a following RET SHALL be treated as an underflow.

Structure
REQ-027 Mode encodings SHALL be defined as named constants in the shared package pc_pkg; WIDTH-dependent types SHALL remain local to the module.
REQ-028 The return-address stack SHALL be a sub-module named pc_ras, with ports push, pop, push_data, top, count and underflow and the same clk/rst, instantiated once.
REQ-029 The next-PC selection SHALL be a single combinational mux feeding one WIDTH-bit register with asynchronous reset.

Verification
REQ-030 Reset then SEQ: pulse rst, then 3 SEQ cycles -> data_out 0040_0000, 0040_0004, 0040_0008, 0040_000C.
REQ-031 Branch: pc=0040_0010, BRANCH with offset=FFFF_FFF0 -> 0040_0004; with ena=0 for 2 cycles -> holds 0040_0004.
REQ-032 Nested calls: from 0040_0000, CALL 100, CALL 200, RET, RET -> data_out 100, 200, 104, 0040_0004; ras_count goes 1, 2, 1, 0.
REQ-033 Overflow: 5 CALLs with RAS_DEPTH=4, then 5 RETs -> the first 4 RETs return in LIFO order, ras_full=1 after the 4th call, and the 5th RET sets ras_underflow.
REQ-034 Wrap-around and reset: SEQ from FFFF_FFFC -> 0000_0000; assert rst asynchronously mid-cycle -> data_out=0040_0000 before the next edge, ras_underflow=0.
